// File: rtl/link_tx_arbiter_if.sv
// link_tx_arbiter_if: client request/grant signals plus the connection_module
// transmit-side registers. The arbiter connects through the master modport and
// the client/link environment through the slave modport.
interface link_tx_arbiter_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRSCL_WIDTH = 8,
  parameter int NUM_REQ     = 4
);
  // Client side. Row k of req_data_i is requester k's word. The packed layout
  // matches a flat vector sliced as [k*DATA_WIDTH +: DATA_WIDTH].
  logic [NUM_REQ-1:0]                 req_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]                 gnt_o;
  logic [NUM_REQ-1:0]                 done_o;
  logic                               err_o;
  // connection_module side.
  logic [PRSCL_WIDTH-1:0]             pre_reg_o;
  logic [PRSCL_WIDTH-1:0]             cmd_reg_o;
  logic [DATA_WIDTH-1:0]              data_o;
  logic [PRSCL_WIDTH-1:0]             status_reg_i;

  modport master (
    input  req_i, req_data_i, status_reg_i,
    output gnt_o, done_o, err_o, pre_reg_o, cmd_reg_o, data_o
  );

  modport slave (
    output req_i, req_data_i, status_reg_i,
    input  gnt_o, done_o, err_o, pre_reg_o, cmd_reg_o, data_o
  );
endinterface

// File: rtl/link_tx_arbiter.sv
// link_tx_arbiter: shares one connection_module transmit path among NUM_REQ
// requesters. It latches the winner's word, issues start, waits for busy to
// fall, and aborts hung transfers on timeout.
// The default build uses round-robin arbitration. Define
// LINK_ARB_FIXED_PRIO_EN for fixed priority, where the lowest index wins and
// no RR pointer exists.

// Per-requester grant level and done pulse.
module link_tx_arb_slot (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sel_i,    // this requester owns the current transfer
  input  logic load_i,   // FSM in LOAD: raise grant
  input  logic fin_i,    // transfer finishing: pulse done in RELEASE
  input  logic clr_i,    // FSM in RELEASE: grant drops next cycle
  output logic gnt_o,
  output logic done_o
);
  logic gnt_q, gnt_d;
  logic done_q, done_d;

  // Grant holds from LOAD through RELEASE; done lasts one cycle.
  always_comb begin
    gnt_d = gnt_q;
    if (load_i && sel_i) gnt_d = 1'b1;
    else if (clr_i)      gnt_d = 1'b0;
    done_d = fin_i & sel_i;
  end

  // Slot registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      gnt_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      done_q <= done_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
endmodule

module link_tx_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRSCL_WIDTH = 8,
  parameter int NUM_REQ     = 4,
  parameter int TMO_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [PRSCL_WIDTH-1:0] prescl_cfg_i,
  input  logic [TMO_WIDTH-1:0]   tmo_cfg_i,
  link_tx_arbiter_if.master      bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_ABORT   = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  localparam logic [PRSCL_WIDTH-1:0] CMD_IDLE  = '0;
  localparam logic [PRSCL_WIDTH-1:0] CMD_START = PRSCL_WIDTH'(1);
  localparam logic [PRSCL_WIDTH-1:0] CMD_ABORT = PRSCL_WIDTH'(2);
  localparam logic [PRSCL_WIDTH-1:0] PRE_ONE   = PRSCL_WIDTH'(1);

  logic [2:0]             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [PRSCL_WIDTH-1:0] pre_q, pre_d;
  logic [PRSCL_WIDTH-1:0] cmd_q, cmd_d;
  logic                   err_flag_q, err_flag_d;
  logic                   err_q, err_d;
  logic [1:0]             st_cnt_q, st_cnt_d;
  logic [TMO_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [TMO_WIDTH-1:0]   tmo_inc;

  logic                   busy;
  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;
  logic                   grant_take;
  logic                   gnt_load, done_set, gnt_clr;
  logic [NUM_REQ-1:0]     gnt_w, done_w;
  logic                   unused_status;

  // Only status bit 0 (tx busy) has meaning; the other bits are ignored.
  assign busy          = bus.status_reg_i[0];
  assign unused_status = ^bus.status_reg_i[PRSCL_WIDTH-1:1];
  assign grant_take    = (state_q == S_IDLE) && win_vld && !busy;

`ifdef LINK_ARB_FIXED_PRIO_EN
  // Fixed priority: the loop runs downward so the lowest set index wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[i]) begin
        win_vld = 1'b1;
        win_idx = i[IDX_W-1:0];
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Round-robin: search upward from ptr with wrap; the smallest offset wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (bus.req_i[j[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = j[IDX_W-1:0];
      end
    end
  end

  // The pointer moves just past each winner when the grant is taken.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_take) ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
  end

  // RR pointer register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  // Saturating busy-cycle counter; it never wraps back to a false match.
  assign tmo_inc = (tmo_cnt_q == {TMO_WIDTH{1'b1}}) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

  // Transfer sequencing: load, start handshake, busy wait/timeout, release.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    data_d     = data_q;
    pre_d      = pre_q;
    cmd_d      = cmd_q;
    err_flag_d = err_flag_q;
    st_cnt_d   = st_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    gnt_load   = 1'b0;
    done_set   = 1'b0;
    gnt_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_take) begin
          owner_d    = win_idx;
          err_flag_d = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        gnt_load = 1'b1;
        data_d   = bus.req_data_i[owner_q];
        pre_d    = (prescl_cfg_i == '0) ? PRE_ONE : prescl_cfg_i;
        cmd_d    = CMD_START;
        st_cnt_d = 2'd0;
        state_d  = S_START;
      end
      S_START: begin
        if (busy) begin
          cmd_d     = CMD_IDLE;
          tmo_cnt_d = '0;
          state_d   = S_WAIT;
        end else if (st_cnt_q == 2'd3) begin
          // Four start cycles without busy: give up and report failure.
          cmd_d      = CMD_IDLE;
          err_flag_d = 1'b1;
          done_set   = 1'b1;
          state_d    = S_RELEASE;
        end else begin
          st_cnt_d = st_cnt_q + 2'd1;
        end
      end
      S_WAIT: begin
        // Busy falling wins over a coincident timeout match.
        if (!busy) begin
          done_set = 1'b1;
          state_d  = S_RELEASE;
        end else begin
          tmo_cnt_d = tmo_inc;
          if ((tmo_cfg_i != '0) && (tmo_inc == tmo_cfg_i)) begin
            cmd_d   = CMD_ABORT;
            state_d = S_ABORT;
          end
        end
      end
      S_ABORT: begin
        cmd_d      = CMD_IDLE;
        err_flag_d = 1'b1;
        done_set   = 1'b1;
        state_d    = S_RELEASE;
      end
      S_RELEASE: begin
        gnt_clr = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d = done_set & err_flag_d;
  end

  // FSM and link-facing registers. connection_module shares reset_i, so a
  // reset needs no abort toward the link.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      data_q     <= '0;
      pre_q      <= PRE_ONE;
      cmd_q      <= CMD_IDLE;
      err_flag_q <= 1'b0;
      err_q      <= 1'b0;
      st_cnt_q   <= 2'd0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      data_q     <= data_d;
      pre_q      <= pre_d;
      cmd_q      <= cmd_d;
      err_flag_q <= err_flag_d;
      err_q      <= err_d;
      st_cnt_q   <= st_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
    link_tx_arb_slot u_slot (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .sel_i   (owner_q == IDX_W'(k)),
      .load_i  (gnt_load),
      .fin_i   (done_set),
      .clr_i   (gnt_clr),
      .gnt_o   (gnt_w[k]),
      .done_o  (done_w[k])
    );
  end

  assign bus.gnt_o     = gnt_w;
  assign bus.done_o    = done_w;
  assign bus.err_o     = err_q;
  assign bus.pre_reg_o = pre_q;
  assign bus.cmd_reg_o = cmd_q;
  assign bus.data_o    = data_q;
endmodule

// File: tb/tb_link_tx_arbiter.sv
// tb_link_tx_arbiter: directed sequence against a connection_module busy stub;
// expected transfers are queued at request time and checked at each done_o.
module tb_link_tx_arbiter;
  localparam int NR = 4, DW = 8, PW = 8, TW = 16;
  localparam int M_NORMAL = 0, M_HANG = 1, M_NEVER = 2, M_BUSYHI = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] prescl;
  logic [TW-1:0] tmo;

  link_tx_arbiter_if #(.DATA_WIDTH(DW), .PRSCL_WIDTH(PW), .NUM_REQ(NR)) bus ();

  link_tx_arbiter #(.DATA_WIDTH(DW), .PRSCL_WIDTH(PW), .NUM_REQ(NR), .TMO_WIDTH(TW)) dut (
    .clk_i        (clk),
    .reset_i      (rst_n),
    .prescl_cfg_i (prescl),
    .tmo_cfg_i    (tmo),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
    logic [7:0] pre;
    logic       err;
  } txn_t;

  txn_t       sb[$];
  txn_t       mt;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] slice [4] = '{8'h90, 8'h81, 8'hB2, 8'hA3};

  // connection_module stub: busy behaviour selected by mode.
  int         mode = M_NORMAL;
  logic       busy;
  logic [7:0] bcnt;
  assign bus.status_reg_i = {7'h5A, busy};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      bcnt <= 8'd0;
    end else begin
      case (mode)
        M_NORMAL: begin
          if (busy) begin
            if (bcnt == 8'd0) busy <= 1'b0;
            else bcnt <= bcnt - 8'd1;
          end else if (bus.cmd_reg_o[0]) begin
            busy <= 1'b1;
            bcnt <= 8'd5;
          end
        end
        M_HANG:  if (bus.cmd_reg_o[0]) busy <= 1'b1;
        M_NEVER: begin busy <= 1'b0; bcnt <= 8'd0; end
        default: begin busy <= 1'b1; bcnt <= 8'd0; end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] oh(input logic [1:0] i);
    return 32'(1) << i;
  endfunction

  task automatic exp_txn(input int idx, input logic [7:0] pre, input logic err);
    txn_t t;
    t.idx  = 2'(idx);
    t.data = slice[idx];
    t.pre  = pre;
    t.err  = err;
    sb.push_back(t);
  endtask

  // Scoreboard check at every completion pulse.
  always @(negedge clk) begin
    if (rst_n && bus.done_o != '0) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'(bus.done_o), 32'(0));
      end else begin
        mt = sb.pop_front();
        chk("done_owner", 32'(bus.done_o), oh(mt.idx));
        chk("done_err", 32'(bus.err_o), 32'(mt.err));
        chk("gnt_at_done", 32'(bus.gnt_o), oh(mt.idx));
        chk("data_at_done", 32'(bus.data_o), 32'(mt.data));
        chk("pre_at_done", 32'(bus.pre_reg_o), 32'(mt.pre));
      end
    end
  end

  task automatic wait_gnt(input string tag, input logic [3:0] exp);
    int n = 0;
    while (bus.gnt_o == '0 && n < 60) begin @(negedge clk); n++; end
    chk(tag, 32'(bus.gnt_o), 32'(exp));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done_o == '0 && n < 400) begin @(negedge clk); n++; end
    chk(tag, 32'(bus.done_o != '0), 32'(1));
    bus.req_i = bus.req_i & ~bus.done_o;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, n, k, c;
    bus.req_i = '0;
    for (int i = 0; i < NR; i++) bus.req_data_i[i] = slice[i];
    prescl = 8'd8;
    tmo    = '0;
    mode   = M_NORMAL;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_gnt",  32'(bus.gnt_o), 32'(0));
    chk("rst_done", 32'(bus.done_o), 32'(0));
    chk("rst_err",  32'(bus.err_o), 32'(0));
    chk("rst_cmd",  32'(bus.cmd_reg_o), 32'(0));
    chk("rst_data", 32'(bus.data_o), 32'(0));
    chk("rst_pre",  32'(bus.pre_reg_o), 32'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // Contention: all four request, each drops after its done.
    bus.req_i = 4'b1111;
    for (int i = 0; i < NR; i++) exp_txn(i, 8'd8, 1'b0);
    for (int i = 0; i < NR; i++) begin
      wait_gnt("contend_gnt", 4'(1 << i));
      wait_done("contend_done");
    end

    // Single request: grant two cycles later, start together with grant.
    repeat (2) @(negedge clk);
    bus.req_i = 4'b0001;
    exp_txn(0, 8'd8, 1'b0);
    @(negedge clk);
    chk("lat_gnt_early", 32'(bus.gnt_o), 32'(0));
    @(negedge clk);
    chk("lat_gnt", 32'(bus.gnt_o), 32'(1));
    chk("lat_start", 32'(bus.cmd_reg_o), 32'(1));
    chk("lat_pre", 32'(bus.pre_reg_o), 32'(8));
    chk("lat_data", 32'(bus.data_o), 32'(8'h90));
    wait_done("single_done");

    // Zero prescaler is forced to 1.
    prescl = 8'd0;
    bus.req_i = 4'b0010;
    exp_txn(1, 8'd1, 1'b0);
    wait_gnt("zp_gnt", 4'b0010);
    chk("zp_pre", 32'(bus.pre_reg_o), 32'(1));
    chk("zp_data", 32'(bus.data_o), 32'(8'h81));
    wait_done("zp_done");
    prescl = 8'd8;

    // Re-raise 0 and 2 together with ptr at 2.
`ifdef LINK_ARB_FIXED_PRIO_EN
    first = 0; second = 2;
`else
    first = 2; second = 0;
`endif
    bus.req_i = 4'b0101;
    exp_txn(first, 8'd8, 1'b0);
    exp_txn(second, 8'd8, 1'b0);
    wait_gnt("rr_first", 4'(1 << first));
    wait_done("rr_first_done");
    wait_gnt("rr_second", 4'(1 << second));
    wait_done("rr_second_done");

    // Link already busy: the arbiter stays idle until busy clears.
    mode = M_BUSYHI;
    repeat (2) @(negedge clk);
    bus.req_i = 4'b1000;
    exp_txn(3, 8'd8, 1'b0);
    repeat (6) @(negedge clk);
    chk("busy_hold_gnt", 32'(bus.gnt_o), 32'(0));
    chk("busy_hold_cmd", 32'(bus.cmd_reg_o), 32'(0));
    mode = M_NORMAL;
    wait_gnt("busy_rel_gnt", 4'b1000);
    wait_done("busy_rel_done");

    // Reset during WAIT_DONE; ptr must restart at 0 (would pick 2 otherwise).
    mode = M_HANG;
    bus.req_i = 4'b0110;
    exp_txn(1, 8'd8, 1'b0);
    wait_gnt("rst_mid_gnt", 4'b0010);
    n = 0;
    while (bus.cmd_reg_o[0] && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt0",  32'(bus.gnt_o), 32'(0));
    chk("rst_mid_cmd0",  32'(bus.cmd_reg_o), 32'(0));
    chk("rst_mid_data0", 32'(bus.data_o), 32'(0));
    chk("rst_mid_pre1",  32'(bus.pre_reg_o), 32'(1));
    chk("rst_mid_done0", 32'(bus.done_o), 32'(0));
    sb.delete();
    mode = M_NORMAL;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_txn(1, 8'd8, 1'b0);
    exp_txn(2, 8'd8, 1'b0);
    wait_gnt("rst_regrant", 4'b0010);
    wait_done("rst_regrant_done");
    wait_gnt("rst_next_gnt", 4'b0100);
    wait_done("rst_next_done");

    // Timeout: busy stuck high, abort 100 cycles after WAIT_DONE entry.
    tmo  = 16'd100;
    mode = M_HANG;
    bus.req_i = 4'b0001;
    exp_txn(0, 8'd8, 1'b1);
    wait_gnt("tmo_gnt", 4'b0001);
    n = 0;
    while (bus.cmd_reg_o[0] && n < 20) begin @(negedge clk); n++; end
    k = 0;
    while (!bus.cmd_reg_o[1] && k < 300) begin @(negedge clk); k++; end
    chk("tmo_latency", 32'(k), 32'(100));
    @(negedge clk);
    chk("abort_one_cycle", 32'(bus.cmd_reg_o[1]), 32'(0));
    wait_done("tmo_done");
    tmo = '0;

    // Start never acknowledged: start held 4 cycles, then error.
    mode = M_NEVER;
    repeat (2) @(negedge clk);
    bus.req_i = 4'b0100;
    exp_txn(2, 8'd8, 1'b1);
    wait_gnt("na_gnt", 4'b0100);
    c = 0; n = 0;
    while (bus.done_o == '0 && n < 50) begin
      if (bus.cmd_reg_o[0]) c++;
      @(negedge clk);
      n++;
    end
    chk("na_start_hold", 32'(c), 32'(4));
    wait_done("na_done");
    chk("na_gnt_drop", 32'(bus.gnt_o), 32'(0));
    mode = M_NORMAL;
    bus.req_i = 4'b1000;
    exp_txn(3, 8'd8, 1'b0);
    wait_gnt("na_recover_gnt", 4'b1000);
    wait_done("na_recover_done");

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
